// File: rtl/expanded_row_scanout.sv
// Read side of the expanded edge-map frame store: fetches one packed row per scanline
// during hblank and serializes it into per-pixel bin codes for the colour/VGA stage.
module expanded_row_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned PIX_W    = 3,
    parameter int unsigned FETCH_H  = 640
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [9:0]                  hcount,
    input  logic [9:0]                  vcount,
    input  logic                        blank,
    output logic [8:0]                  row_addr,
    output logic                        row_en,
    input  logic [H_ACTIVE*PIX_W-1:0]   row_data,
    output logic [PIX_W-1:0]            pixel_code,
    output logic                        pixel_valid,
    output logic                        underrun,
    output logic                        frame_done
);

    localparam int unsigned ROW_W = H_ACTIVE * PIX_W;
    localparam int unsigned IDX_W = $clog2(ROW_W);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

    state_t               state;
    logic [ROW_W-1:0]     row_buf;
    logic                 buf_valid;
    logic                 armed;
    // Set while disabled; only a row-0 fetch clears it, so re-enable resyncs on a frame boundary.
    logic                 hold;

    logic [9:0]           next_row_c;
    logic                 fetch_go_c;
    logic                 in_range_c;
    logic [IDX_W-1:0]     pix_idx_c;
    logic [IDX_W-1:0]     base_c;
    logic [PIX_W-1:0]     sel_c;

    // Next-row selection, fetch trigger and pixel select (pixel 0 sits at the MSB end).
    always_comb begin
        next_row_c = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
        fetch_go_c = enable && (hcount == 10'(FETCH_H)) && (next_row_c < 10'(V_ACTIVE))
                     && (!hold || (next_row_c == 10'd0));
        in_range_c = (hcount < 10'(H_ACTIVE));
        pix_idx_c  = in_range_c ? (IDX_W'(H_ACTIVE - 1) - IDX_W'(hcount)) : '0;
        base_c     = IDX_W'(PIX_W) * pix_idx_c;
        sel_c      = row_buf[base_c +: PIX_W];
    end

    // Fetch FSM, line bookkeeping and registered pixel output.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            row_addr    <= '0;
            row_en      <= 1'b0;
            pixel_code  <= '0;
            pixel_valid <= 1'b0;
            underrun    <= 1'b0;
            frame_done  <= 1'b0;
            buf_valid   <= 1'b0;
            armed       <= 1'b0;
            hold        <= 1'b0;
        end else begin
            row_en     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fetch_go_c) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    row_addr <= 9'(next_row_c);
                    row_en   <= 1'b1;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    buf_valid <= 1'b1;
                    if (row_addr == 9'(V_ACTIVE - 1)) frame_done <= 1'b1;
                    if (row_addr == 9'd0) begin
                        armed <= 1'b1;
                        hold  <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (hcount == 10'(H_ACTIVE)) buf_valid <= 1'b0;

            if (enable && (hcount == 10'd0) && (vcount < 10'(V_ACTIVE)) && armed && !buf_valid)
                underrun <= 1'b1;

            if (!enable) begin
                armed     <= 1'b0;
                hold      <= 1'b1;
                buf_valid <= 1'b0;
            end

            if (enable && !blank && in_range_c && buf_valid) begin
                pixel_code  <= sel_c;
                pixel_valid <= 1'b1;
            end else begin
                pixel_code  <= '0;
                pixel_valid <= 1'b0;
            end
        end
    end

    // Row buffer is pure datapath; validity is tracked by buf_valid.
    always_ff @(posedge clock) begin
        if (reset && (state == S_CAPTURE)) row_buf <= row_data;
    end

endmodule
